memwb_stage_reg: RTL and testbench

Parametrised MEM/WB pipeline register for the pipelined processor, replacing the plain pass-through stage with a clocked, flow-controlled stage. It captures the write-back control bits, memory read data, ALU result and destination register from MEM, and holds them for WB under a valid/ready handshake. A two-entry skid buffer keeps the upstream ready signal fully registered. Flush and bubble insertion are supported, along with an optional forwarding tap for the hazard unit.

---
 rtl/memwb_stage_reg.sv | 140 ++++++++++++++
 tb/tb_memwb_stage_reg.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/memwb_stage_reg.sv
// memwb_stage_reg: MEM/WB pipeline register with valid/ready flow control.
//
// Holds the write-back bundle (control, read data, ALU result, rd) for the WB
// stage. A two-entry skid buffer (main + skid) lets mem_ready come straight
// from a flop instead of being a combinational function of wb_ready.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop all held entries (highest priority)
//   mem_valid/mem_ready upstream handshake (mem_ready is registered)
//   wb_ctrl_mem, data_read_mem, alu_result_mem, rd_mem   entry from MEM
//   wb_valid/wb_ready   downstream handshake
//   wb_ctrl_wb, data_read_wb, alu_result_wb, rd_wb       main entry to WB
//   wb_data             MemtoReg ? data_read_wb : alu_result_wb
//   fwd_en/fwd_rd/fwd_data  forwarding tap, only when MEMWB_FWD_EN is defined
//
// Build option: define MEMWB_FWD_EN to add the forwarding tap ports.
module memwb_stage_reg #(
  parameter int WB_CTRL_W = 2,
  parameter int DATA_W    = 64,
  parameter int RD_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [WB_CTRL_W-1:0] wb_ctrl_mem,
  input  logic [DATA_W-1:0]    data_read_mem,
  input  logic [DATA_W-1:0]    alu_result_mem,
  input  logic [RD_W-1:0]      rd_mem,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [WB_CTRL_W-1:0] wb_ctrl_wb,
  output logic [DATA_W-1:0]    data_read_wb,
  output logic [DATA_W-1:0]    alu_result_wb,
  output logic [RD_W-1:0]      rd_wb,
  output logic [DATA_W-1:0]    wb_data
`ifdef MEMWB_FWD_EN
  ,
  output logic                 fwd_en,
  output logic [RD_W-1:0]      fwd_rd,
  output logic [DATA_W-1:0]    fwd_data
`endif
);

  typedef struct packed {
    logic [WB_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]    rdat;
    logic [DATA_W-1:0]    alu;
    logic [RD_W-1:0]      rd;
  } ent_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t state_q, state_d;
  ent_t   main_q, main_d, skid_q, skid_d, in_ent;
  logic   mem_ready_q, mem_ready_d;
  logic   main_vld, accept, drain;

  assign in_ent   = '{ctrl: wb_ctrl_mem, rdat: data_read_mem,
                      alu: alu_result_mem, rd: rd_mem};
  assign main_vld = (state_q != S_EMPTY);
  // mem_ready_q is low exactly in SKID, so no accept can happen there.
  assign accept   = mem_valid & mem_ready_q;
  assign drain    = main_vld & wb_ready;

  // State register (plus data and registered ready)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      mem_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (accept) state_d = S_FULL;
        S_FULL: begin
          if (accept && !drain)      state_d = S_SKID;
          else if (!accept && drain) state_d = S_EMPTY;
        end
        S_SKID:  if (drain) state_d = S_FULL;
        default: state_d = S_EMPTY;
      endcase
    end
    // Ready for next cycle is known from the next state alone, so it can be a flop.
    mem_ready_d = (state_d != S_SKID);
  end

  // Data movement; a flush leaves the data flops stale on purpose.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      unique case (state_q)
        S_EMPTY: if (accept) main_d = in_ent;
        S_FULL: begin
          if (accept && drain) main_d = in_ent;
          else if (accept)     skid_d = in_ent;
        end
        S_SKID:  if (drain) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem_ready     = mem_ready_q;
    wb_valid      = main_vld;
    // Forced to zero on a bubble so RegWrite can never fire.
    wb_ctrl_wb    = main_vld ? main_q.ctrl : '0;
    data_read_wb  = main_q.rdat;
    alu_result_wb = main_q.alu;
    rd_wb         = main_q.rd;
    wb_data       = wb_ctrl_wb[0] ? main_q.rdat : main_q.alu;
  end

`ifdef MEMWB_FWD_EN
  always_comb begin
    fwd_en   = wb_valid & wb_ctrl_wb[1] & (rd_wb != '0);
    fwd_rd   = fwd_en ? rd_wb : '0;
    fwd_data = fwd_en ? wb_data : '0;
  end
`endif

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Bench for memwb_stage_reg: directed cases then random traffic, compared
// against a FIFO model (at most two entries held, head drives WB).
module tb_memwb_stage_reg;
  localparam int CW = 2, DW = 64, RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, mem_valid, wb_ready;
  logic          mem_ready, wb_valid;
  logic [CW-1:0] wb_ctrl_mem, wb_ctrl_wb;
  logic [DW-1:0] data_read_mem, alu_result_mem, data_read_wb, alu_result_wb, wb_data;
  logic [RW-1:0] rd_mem, rd_wb;
`ifdef MEMWB_FWD_EN
  logic          fwd_en;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  memwb_stage_reg #(.WB_CTRL_W(CW), .DATA_W(DW), .RD_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .wb_ctrl_mem(wb_ctrl_mem), .data_read_mem(data_read_mem),
    .alu_result_mem(alu_result_mem), .rd_mem(rd_mem),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_ctrl_wb(wb_ctrl_wb), .data_read_wb(data_read_wb),
    .alu_result_wb(alu_result_wb), .rd_wb(rd_wb), .wb_data(wb_data)
`ifdef MEMWB_FWD_EN
    , .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rdat;
    logic [DW-1:0] alu;
    logic [RW-1:0] rd;
  } ent_t;

  ent_t mq[$];
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model head.
  task automatic chk_all(input string tag);
    bit       v;
    logic [DW-1:0] wd;
    v = (mq.size() > 0);
    chk({tag, ".wb_valid"}, DW'(wb_valid), DW'(v));
    chk({tag, ".mem_ready"}, DW'(mem_ready), DW'(mq.size() < 2));
    if (v) begin
      wd = mq[0].ctrl[0] ? mq[0].rdat : mq[0].alu;
      chk({tag, ".ctrl"}, DW'(wb_ctrl_wb), DW'(mq[0].ctrl));
      chk({tag, ".rdat"}, data_read_wb, mq[0].rdat);
      chk({tag, ".alu"}, alu_result_wb, mq[0].alu);
      chk({tag, ".rd"}, DW'(rd_wb), DW'(mq[0].rd));
      chk({tag, ".wb_data"}, wb_data, wd);
    end else begin
      chk({tag, ".ctrl_bubble"}, DW'(wb_ctrl_wb), '0);
    end
`ifdef MEMWB_FWD_EN
    begin
      bit fe;
      fe = v && mq[0].ctrl[1] && (mq[0].rd != 0);
      chk({tag, ".fwd_en"}, DW'(fwd_en), DW'(fe));
      chk({tag, ".fwd_rd"}, DW'(fwd_rd), fe ? DW'(mq[0].rd) : '0);
      chk({tag, ".fwd_data"}, fwd_data, fe ? (mq[0].ctrl[0] ? mq[0].rdat : mq[0].alu) : '0);
    end
`endif
  endtask

  // One clock: decide handshakes from current inputs/model, advance, check.
  task automatic cycle(input string tag);
    bit acc, drn;
    ent_t e;
    acc = mem_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && wb_ready;
    e = '{ctrl: wb_ctrl_mem, rdat: data_read_mem, alu: alu_result_mem, rd: rd_mem};
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] r,
                       input logic [DW-1:0] a, input logic [RW-1:0] d);
    mem_valid = v; wb_ctrl_mem = c; data_read_mem = r; alu_result_mem = a; rd_mem = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    drive(1'b1, 2'b11, 64'h1111, 64'h2222, 5'd3);
    @(negedge clk);
    // Reset held 2 cycles with mem_valid high
    cycle("rst0");
    cycle("rst1");
    chk("rst.rdat", data_read_wb, '0);
    chk("rst.alu", alu_result_wb, '0);
    chk("rst.rd", DW'(rd_wb), '0);
    chk("rst.wb_data", wb_data, '0);
    rst_n = 1'b1;
    cycle("first_acc");
    drive(1'b0, '0, '0, '0, '0);
    cycle("idle");

    // Streaming
    drive(1'b1, 2'b10, 64'h5, 64'h10, 5'd1); cycle("str0");
    drive(1'b1, 2'b10, 64'h5, 64'h20, 5'd2); cycle("str1");
    drive(1'b1, 2'b10, 64'h5, 64'h30, 5'd3); cycle("str2");
    drive(1'b0, '0, '0, '0, '0); cycle("str3");

    // Backpressure into skid, then drain in order
    wb_ready = 1'b0;
    drive(1'b1, 2'b10, 64'h0, 64'hA, 5'd4); cycle("bp_a");
    drive(1'b1, 2'b10, 64'h0, 64'hB, 5'd5); cycle("bp_b");
    drive(1'b1, 2'b10, 64'h0, 64'hC, 5'd6); cycle("bp_hold");
    drive(1'b0, '0, '0, '0, '0);
    wb_ready = 1'b1;
    cycle("bp_drain_a");
    cycle("bp_drain_b");

    // MemtoReg select
    drive(1'b1, 2'b11, 64'hDEAD, 64'hBEEF, 5'd7); cycle("m2r1");
    drive(1'b1, 2'b10, 64'hDEAD, 64'hBEEF, 5'd7); cycle("m2r0");
    drive(1'b1, 2'b10, 64'h0, 64'h55, 5'd0); cycle("rd0");
    drive(1'b1, 2'b10, 64'h0, 64'h55, 5'd7); cycle("rd7");
    drive(1'b0, '0, '0, '0, '0); cycle("m2r_idle");

    // Flush while in SKID with mem_valid high
    wb_ready = 1'b0;
    drive(1'b1, 2'b10, 64'h0, 64'h77, 5'd8); cycle("fl_a");
    drive(1'b1, 2'b10, 64'h0, 64'h88, 5'd9); cycle("fl_b");
    flush = 1'b1;
    drive(1'b1, 2'b11, 64'h99, 64'h99, 5'd10); cycle("flush");
    flush = 1'b0; wb_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    cycle("fl_after0");
    cycle("fl_after1");

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, RW'($urandom));
      wb_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      rst_n    = ($urandom_range(0, 59) != 0);
      cycle("rand");
    end
    rst_n = 1'b1; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
